hs_tx_bridge: RTL
=================

# hs_tx_bridge

Clocked transmitter for the two-phase bundled-data handshake used by the asynchronous datapath blocks: it accepts words from a synchronous valid/ready source, buffers them in a small FIFO, and issues each word on an `io_Out_HS_*` channel by toggling Req and waiting for the matching Ack toggle. It is the synchronous-domain producer feeding input channels of async operators such as the adder and multiplier stages.

## Interface
- `WIDTH`, 8: data width in bits.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `io_In_valid`  in  1: source word present.
- `io_In_ready`  out  1: FIFO can accept; equals `!full`.
- `io_In_bits`  in  WIDTH: source word.
- `io_Out_HS_Req`  out  1: two-phase request; every toggle is one transfer.
- `io_Out_HS_Ack`  in  1: two-phase acknowledge from the async receiver; asynchronous to `clock`.
- `io_Out_Data`  out  WIDTH: bundled data, held stable from one cycle before each Req toggle until the matching Ack.

## Operation
- Reset values: `io_Out_HS_Req`=0, `io_Out_Data`=0, FIFO empty, `io_In_ready`=1, FSM in IDLE, both Ack synchroniser flops=0.
- FIFO: push on `io_In_valid && io_In_ready`. Pop only by the FSM load. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH. The count is `clog2(DEPTH)+1` bits.
- Ack is synchronised through 2 flops to give `ack_s`. A transfer is outstanding while `ack_s != io_Out_HS_Req`.
- FSM states:
  - IDLE: if the FIFO is non-empty, `io_Out_Data` <= head, pop, and go to SETUP. Otherwise stay.
  - SETUP: `io_Out_HS_Req` <= `~io_Out_HS_Req`. Go to WAIT_ACK.
  - WAIT_ACK: when `ack_s == io_Out_HS_Req`, the transfer is complete. If the FIFO is non-empty, load head into `io_Out_Data`, pop, and go to SETUP. Otherwise go to IDLE.
- `io_Out_Data` changes only on a load, and a load happens only when no transfer is outstanding. This is the bundled-data guarantee.
- An Ack toggle seen while no transfer is outstanding is a protocol error. It is ignored except that it desynchronises the phases. The receiver must not do this.
- Reset mid-transfer: all outputs return to their reset values immediately. The receiver must be reset in the same window so that Ack also returns to 0.

## Timing
- Accept at edge E0 gives load at E1 and the Req toggle at E2. Minimum latency from accept to Req is 2 cycles.
- The Ack toggle is seen as `ack_s` 2–3 edges after it arrives. The next load happens on the edge where `ack_s` matches, and the next Req toggles one edge later.
- Back-to-back throughput is one word per (Ack round-trip + about 4 cycles).
- `io_In_ready` is registered-state only, with no combinational path from `io_In_valid`.

## Configuration
- Macro: `HS_TX_STATUS_EN`.
- When defined, the module adds output `io_Sent` (16 bits, reset 0). It increments by 1 on each completed transfer, meaning the cycle WAIT_ACK sees `ack_s == io_Out_HS_Req`, and wraps from 0xFFFF to 0x0000.
- When undefined, the port and its counter are absent and all other behaviour is identical.

## Test plan
- Reset check: assert `reset` mid-cycle with no clock edge. Req=0, Data=0 and ready=1 must hold immediately. The bench acts as receiver with `Ack = #5 Req` and a 10 ns clock.
- Single word: push 0x5A at E0. Data=0x5A at E1 and Req goes 0→1 at E2. After the echoed Ack, FSM is in IDLE with Req=1.
- Burst: push 0x01, 0x02, 0x03, 0x04 on consecutive cycles. Req toggles exactly 4 times and Data shows 0x01–0x04 in order. Data never changes while Req≠Ack. With `HS_TX_STATUS_EN`, `io_Sent`=4.
- Full FIFO: hold Ack, push 5 words with DEPTH=4. One word is in flight and four are buffered. Ready drops to 0 after the 5th push and the 6th word is not accepted. Ready returns to 1 the cycle after the next pop.
- Slow receiver: delay Ack by 200 ns. Req must not toggle again and Data must stay fixed until 2–3 cycles after Ack arrives.
- Reset mid-transfer: assert reset while Req=1 and Ack=0. Req goes to 0 and the FIFO empties. After release, push 0xA5; it transfers normally with Req toggling 0→1.

Source files
------------

// File: rtl/hs_tx_bridge_if.sv
// rtl/hs_tx_bridge_if.sv - signal bundle between a valid/ready source, hs_tx_bridge and a two-phase receiver
//
// Signals:
//   io_In_valid   source word present (source -> bridge)
//   io_In_ready   bridge can accept a word (bridge -> source)
//   io_In_bits    source word, WIDTH bits (source -> bridge)
//   io_Out_HS_Req two-phase request; every toggle is one transfer (bridge -> receiver)
//   io_Out_HS_Ack two-phase acknowledge, asynchronous to the clock (receiver -> bridge)
//   io_Out_Data   bundled data, WIDTH bits (bridge -> receiver)
//   io_Sent       completed-transfer counter, 16 bits (only with HS_TX_STATUS_EN)
// Modports: slave = bridge side, master = source/receiver side.
`timescale 1ns/1ps
interface hs_tx_bridge_if #(
   parameter int WIDTH = 8
);
   logic             io_In_valid;
   logic             io_In_ready;
   logic [WIDTH-1:0] io_In_bits;
   logic             io_Out_HS_Req;
   logic             io_Out_HS_Ack;
   logic [WIDTH-1:0] io_Out_Data;
`ifdef HS_TX_STATUS_EN
   logic [15:0]      io_Sent;

   modport slave (
      input  io_In_valid, io_In_bits, io_Out_HS_Ack,
      output io_In_ready, io_Out_HS_Req, io_Out_Data, io_Sent
   );
   modport master (
      output io_In_valid, io_In_bits, io_Out_HS_Ack,
      input  io_In_ready, io_Out_HS_Req, io_Out_Data, io_Sent
   );
`else
   modport slave (
      input  io_In_valid, io_In_bits, io_Out_HS_Ack,
      output io_In_ready, io_Out_HS_Req, io_Out_Data
   );
   modport master (
      output io_In_valid, io_In_bits, io_Out_HS_Ack,
      input  io_In_ready, io_Out_HS_Req, io_Out_Data
   );
`endif
endinterface

// File: rtl/hs_tx_bridge.sv
// rtl/hs_tx_bridge.sv - valid/ready to two-phase bundled-data transmitter with a small FIFO
//
// Purpose: buffers words from a synchronous valid/ready source and issues each one on a
// two-phase Req/Ack channel. Data is loaded only while no transfer is outstanding, and Req
// toggles one cycle after the load, so the data is stable before and during every request.
// Ports:
//   clock  single clock, rising edge
//   reset  asynchronous, active-high; clears all state
//   bus    hs_tx_bridge_if.slave (io_In_*, io_Out_HS_Req/Ack, io_Out_Data[, io_Sent])
// Parameters: WIDTH data bits, DEPTH FIFO entries (power of two, >= 2).
// Optional feature macro: HS_TX_STATUS_EN adds the 16-bit io_Sent transfer counter.
`timescale 1ns/1ps
module hs_tx_bridge #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic           clock,
   input  logic           reset,
   hs_tx_bridge_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             req_q, req_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ack_meta_q, ack_s_q;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             full, empty, push, pop;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   // ready depends on registered count only, never on io_In_valid
   assign push  = bus.io_In_valid && !full;

   assign bus.io_In_ready   = !full;
   assign bus.io_Out_HS_Req = req_q;
   assign bus.io_Out_Data   = data_q;

   // Ack comes from an unclocked receiver; two flops before anything looks at it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         ack_meta_q <= bus.io_Out_HS_Ack;
         ack_s_q    <= ack_meta_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= bus.io_In_bits;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               data_d  = mem_q[rd_ptr_q];
               pop     = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            // data was loaded on the previous edge, so it leads the Req toggle by a cycle
            req_d   = ~req_q;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack_s_q == req_q) begin
               if (!empty) begin
                  data_d  = mem_q[rd_ptr_q];
                  pop     = 1'b1;
                  state_d = SETUP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef HS_TX_STATUS_EN
   logic [15:0] sent_q;
   logic        done;

   assign done        = (state_q == WAIT_ACK) && (ack_s_q == req_q);
   assign bus.io_Sent = sent_q;

   // wraps naturally from 0xFFFF to 0x0000
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sent_q <= 16'h0000;
      end else if (done) begin
         sent_q <= sent_q + 16'h0001;
      end
   end
`endif
endmodule
